// File: rtl/hfnc_pkg.sv
// Shared types and defaults for the hash-function-unit issue controller.
// The watchdog is enabled by defining HFNC_WDT_EN.
package hfnc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } hfncState_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         WDT_LIMIT_DEF = 64;
  localparam int         CNT_W_DEF     = 16;

endpackage

// File: rtl/hfnc_hazard_detect.sv
// Load-use hazard compare of the EX-stage load destination against the three
// ID-stage source fields (Ru only counts for hash instructions).
module hfnc_hazard_detect
  import hfnc_pkg::*;
(
  input  logic       idValid,
  input  logic       idIsHash,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic [4:0] idRu,
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  output logic       lu
);

  logic rdLive;
  logic matchRs;
  logic matchRt;
  logic matchRu;

  // r0 is hardwired, so a load targeting it can never create a dependency
  assign rdLive  = exMemRead && (exRd != REG_ZERO);
  assign matchRs = (exRd == idRs);
  assign matchRt = (exRd == idRt);
  assign matchRu = idIsHash && (exRd == idRu);

  assign lu = idValid && rdLive && (matchRs || matchRt || matchRu);

endmodule

// File: rtl/hfnc_issue_ctrl.sv
// Issue/stall controller for the multi-cycle hash-function unit in EX.
// Optional watchdog abort is built when HFNC_WDT_EN is defined (WDT_LIMIT >= 2).
module hfnc_issue_ctrl
  import hfnc_pkg::*;
#(
  parameter int WDT_LIMIT = WDT_LIMIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_hash,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_ru,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             hfu_done,
  input  logic             stat_clr,
  output logic             hfu_start,
  output logic             hfu_abort,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             hfu_result_sel,
  output logic             wdt_err,
  output logic [CNT_W-1:0] busy_cycles,
  output hfncState_t       dbgState
);

  hfncState_t state;
  hfncState_t stateNext;

  logic lu;
  logic luLive;
  logic issue;
  logic doneValid;
  logic wdtFire;

  hfnc_hazard_detect uHazard (
    .idValid   (id_valid),
    .idIsHash  (id_is_hash),
    .idRs      (id_rs),
    .idRt      (id_rt),
    .idRu      (id_ru),
    .exMemRead (ex_mem_read),
    .exRd      (ex_rd),
    .lu        (lu)
  );

  // Start/done handshake: hfu_start is a one-cycle pulse in the first BUSY
  // cycle; hfu_done is a one-cycle pulse honoured only in BUSY and only when
  // it does not coincide with hfu_start.
  assign luLive    = lu && rst_n;
  assign issue     = (state == IDLE) && id_valid && id_is_hash && !lu;
  assign doneValid = (state == BUSY) && hfu_done && !hfu_start;
  assign dbgState  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hfu_start   <= 1'b0;
      busy_cycles <= '0;
    end else begin
      state     <= stateNext;
      hfu_start <= issue;
      if (stat_clr)
        busy_cycles <= '0;
      else if ((state == BUSY) && (busy_cycles != '1))
        busy_cycles <= busy_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext      = state;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    hfu_result_sel = 1'b0;
    case (state)
      IDLE: begin
        if (luLive) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (issue)
          stateNext = BUSY;
      end
      BUSY: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        ex_mem_flush = 1'b1;
        // an aborted hash is killed in ID/EX rather than held there
        id_ex_stall  = !wdtFire;
        id_ex_flush  = wdtFire;
        if (wdtFire)
          stateNext = IDLE;
        else if (doneValid)
          stateNext = DONE;
      end
      DONE: begin
        hfu_result_sel = 1'b1;
        stateNext      = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef HFNC_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] wdtCnt;
  logic             abortArm;

  // wdtCnt holds k-1 in BUSY cycle k; arming one cycle early lets the
  // registered abort land exactly in BUSY cycle WDT_LIMIT
  assign abortArm = (state == BUSY) && !doneValid && !hfu_abort &&
                    (wdtCnt == WDT_W'(WDT_LIMIT - 2));
  assign wdtFire  = (state == BUSY) && hfu_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdtCnt    <= '0;
      hfu_abort <= 1'b0;
      wdt_err   <= 1'b0;
    end else begin
      hfu_abort <= abortArm;
      if (abortArm)
        wdt_err <= 1'b1;
      if (issue)
        wdtCnt <= '0;
      else if ((state == BUSY) && (wdtCnt != '1))
        wdtCnt <= wdtCnt + WDT_W'(1);
    end
  end
`else
  logic unusedWdtLimit;

  assign unusedWdtLimit = (WDT_LIMIT > 0);
  assign wdtFire        = 1'b0;
  assign hfu_abort      = 1'b0;
  assign wdt_err        = 1'b0;
`endif

endmodule

// File: tb/tb_hfnc_issue_ctrl.sv
// Directed bench for hfnc_issue_ctrl: hazard vector table plus cycle-level
// sequences for issue timing, done filtering, counter, reset and watchdog.
module tb_hfnc_issue_ctrl;
  import hfnc_pkg::*;

  localparam int CNT_W     = 16;
  localparam int WDT_LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_is_hash, ex_mem_read, hfu_done, stat_clr;
  logic [4:0] id_rs, id_rt, id_ru, ex_rd;

  logic hfu_start, hfu_abort, pc_stall, if_id_stall, id_ex_stall;
  logic id_ex_flush, ex_mem_flush, hfu_result_sel, wdt_err;
  logic [CNT_W-1:0] busy_cycles;
  hfncState_t dbgState;

  logic sStart, sAbort, sPc, sIfId, sIdExS, sIdExF, sExMemF, sSel, sWdt;
  logic [1:0] sBusy;
  hfncState_t sState;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  hfnc_issue_ctrl #(.WDT_LIMIT(WDT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_hash(id_is_hash),
    .id_rs(id_rs), .id_rt(id_rt), .id_ru(id_ru), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .hfu_done(hfu_done), .stat_clr(stat_clr),
    .hfu_start(hfu_start), .hfu_abort(hfu_abort), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .hfu_result_sel(hfu_result_sel), .wdt_err(wdt_err),
    .busy_cycles(busy_cycles), .dbgState(dbgState)
  );

  // narrow-counter copy so saturation is reachable in a few cycles
  hfnc_issue_ctrl #(.WDT_LIMIT(WDT_LIMIT), .CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_hash(id_is_hash),
    .id_rs(id_rs), .id_rt(id_rt), .id_ru(id_ru), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .hfu_done(hfu_done), .stat_clr(stat_clr),
    .hfu_start(sStart), .hfu_abort(sAbort), .pc_stall(sPc),
    .if_id_stall(sIfId), .id_ex_stall(sIdExS), .id_ex_flush(sIdExF),
    .ex_mem_flush(sExMemF), .hfu_result_sel(sSel), .wdt_err(sWdt),
    .busy_cycles(sBusy), .dbgState(sState)
  );

  typedef struct {
    logic       v;
    logic       h;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] ru;
    logic       ld;
    logic [4:0] rd;
    logic       expStall;
  } hzVec_t;

  hzVec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearIn();
    id_valid = 1'b0; id_is_hash = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_ru = 5'd0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; hfu_done = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveHash();
    id_valid = 1'b1; id_is_hash = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_ru = 5'd3;
  endtask

  task automatic clearStats();
    nextCycle(); stat_clr = 1'b1;
    nextCycle(); stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr_idle", busy_cycles, 0);
  endtask

  // hash in ID during cycle N, hfu_done in BUSY cycle doneAt
  task automatic hashSeq(input string tag, input int doneAt, input int busyExp);
    nextCycle(); driveHash();
    @(negedge clk);
    chk({tag, "_n_state"}, dbgState, IDLE);
    chk({tag, "_n_stall"}, pc_stall, 0);
    for (int k = 1; k <= doneAt; k++) begin
      nextCycle(); id_valid = 1'b0; hfu_done = (k == doneAt);
      @(negedge clk);
      chk({tag, "_b_state"}, dbgState, BUSY);
      chk({tag, "_b_pc"}, pc_stall, 1);
      chk({tag, "_b_ifid"}, if_id_stall, 1);
      chk({tag, "_b_idex"}, id_ex_stall, 1);
      chk({tag, "_b_exmem"}, ex_mem_flush, 1);
      chk({tag, "_b_start"}, hfu_start, (k == 1));
      chk({tag, "_b_sel"}, hfu_result_sel, 0);
    end
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk({tag, "_d_state"}, dbgState, DONE);
    chk({tag, "_d_sel"}, hfu_result_sel, 1);
    chk({tag, "_d_pc"}, pc_stall, 0);
    chk({tag, "_d_idex"}, id_ex_stall, 0);
    chk({tag, "_d_exmem"}, ex_mem_flush, 0);
    chk({tag, "_d_busy"}, busy_cycles, busyExp);
    nextCycle();
    @(negedge clk);
    chk({tag, "_i_state"}, dbgState, IDLE);
    chk({tag, "_i_sel"}, hfu_result_sel, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 5'd7,  1'b1};
    vecs[1] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd7,  1'b1, 5'd7,  1'b0};
    vecs[2] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0,  1'b1, 5'd0,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'd7, 5'd2, 5'd3,  1'b1, 5'd7,  1'b1};
    vecs[4] = '{1'b1, 1'b0, 5'd1, 5'd7, 5'd3,  1'b1, 5'd7,  1'b1};
    vecs[5] = '{1'b1, 1'b1, 5'd7, 5'd7, 5'd7,  1'b0, 5'd7,  1'b0};
    vecs[6] = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd7,  1'b1, 5'd7,  1'b0};
    vecs[7] = '{1'b1, 1'b1, 5'd1, 5'd2, 5'd31, 1'b1, 5'd31, 1'b1};

    clearIn();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", dbgState, IDLE);
    chk("rst_start", hfu_start, 0);
    chk("rst_abort", hfu_abort, 0);
    chk("rst_sel", hfu_result_sel, 0);
    chk("rst_wdt", wdt_err, 0);
    chk("rst_busy", busy_cycles, 0);

    // combinational hazard table, applied mid-cycle and withdrawn before the edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      id_valid = vecs[i].v; id_is_hash = vecs[i].h;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_ru = vecs[i].ru;
      ex_mem_read = vecs[i].ld; ex_rd = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d_pc", i), pc_stall, vecs[i].expStall);
      chk($sformatf("vec%0d_ifid", i), if_id_stall, vecs[i].expStall);
      chk($sformatf("vec%0d_flush", i), id_ex_flush, vecs[i].expStall);
      chk($sformatf("vec%0d_idex", i), id_ex_stall, 0);
      clearIn();
    end
    @(negedge clk);
    chk("vec_state", dbgState, IDLE);

    // load-use on Ru costs one cycle, then the hash issues
    nextCycle(); driveHash(); id_ru = 5'd7; ex_mem_read = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    chk("lu_pc", pc_stall, 1);
    chk("lu_flush", id_ex_flush, 1);
    chk("lu_state", dbgState, IDLE);
    nextCycle(); ex_mem_read = 1'b0;
    @(negedge clk);
    chk("lu2_pc", pc_stall, 0);
    chk("lu2_flush", id_ex_flush, 0);
    nextCycle(); id_valid = 1'b0;
    @(negedge clk);
    chk("lu3_state", dbgState, BUSY);
    chk("lu3_start", hfu_start, 1);
    nextCycle(); hfu_done = 1'b1;
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("lu_done_state", dbgState, DONE);
    nextCycle();

    // main timing: done in 4th BUSY cycle
    clearStats();
    hashSeq("main", 4, 4);

    // hfu_done in IDLE is ignored
    nextCycle(); hfu_done = 1'b1;
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("idle_done_state", dbgState, IDLE);
    chk("idle_done_sel", hfu_result_sel, 0);

    // done coincident with start is dropped; a later one completes
    nextCycle(); driveHash();
    nextCycle(); id_valid = 1'b0; hfu_done = 1'b1;
    @(negedge clk);
    chk("coin_start", hfu_start, 1);
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("coin_ignored", dbgState, BUSY);
    nextCycle(); hfu_done = 1'b1;
    @(negedge clk);
    chk("coin_wait", dbgState, BUSY);
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("coin_done", dbgState, DONE);
    nextCycle();

    // saturation on the 2-bit copy, 7 BUSY cycles
    clearStats();
    hashSeq("sat", 7, 7);
    chk("sat_small", sBusy, 3);
    chk("sat_nowdt", wdt_err, 0);

    // stat_clr during BUSY wins over the increment
    clearStats();
    nextCycle(); driveHash();
    for (int k = 1; k <= 5; k++) begin
      nextCycle(); id_valid = 1'b0; stat_clr = (k == 3); hfu_done = (k == 5);
      @(negedge clk);
      if (k == 3) chk("clr_before", busy_cycles, 2);
      if (k == 4) chk("clr_zero", busy_cycles, 0);
      if (k == 5) chk("clr_after", busy_cycles, 1);
    end
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("clr_done_busy", busy_cycles, 2);
    nextCycle();

    // asynchronous reset in the 3rd BUSY cycle
    nextCycle(); driveHash();
    for (int k = 1; k <= 3; k++) begin
      nextCycle(); id_valid = 1'b0;
    end
    @(negedge clk);
    chk("prerst_state", dbgState, BUSY);
    id_valid = 1'b1; id_rs = 5'd7; ex_mem_read = 1'b1; ex_rd = 5'd7;
    rst_n = 1'b0;
    #1;
    chk("arst_state", dbgState, IDLE);
    chk("arst_pc", pc_stall, 0);
    chk("arst_ifid", if_id_stall, 0);
    chk("arst_idex", id_ex_stall, 0);
    chk("arst_flush", id_ex_flush, 0);
    chk("arst_exmem", ex_mem_flush, 0);
    chk("arst_start", hfu_start, 0);
    chk("arst_busy", busy_cycles, 0);
    clearIn();
    @(negedge clk);
    #2 rst_n = 1'b1;
    hashSeq("postrst", 2, 2);

`ifdef HFNC_WDT_EN
    nextCycle(); driveHash();
    for (int k = 1; k <= 8; k++) begin
      nextCycle(); id_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("wdt%0d_state", k), dbgState, BUSY);
      chk($sformatf("wdt%0d_abort", k), hfu_abort, (k == 8));
      chk($sformatf("wdt%0d_flush", k), id_ex_flush, (k == 8));
      chk($sformatf("wdt%0d_err", k), wdt_err, (k == 8));
    end
    nextCycle();
    @(negedge clk);
    chk("wdt_idle", dbgState, IDLE);
    chk("wdt_abort_off", hfu_abort, 0);
    chk("wdt_sticky", wdt_err, 1);
    nextCycle();
    @(negedge clk);
    chk("wdt_sticky2", wdt_err, 1);
    rst_n = 1'b0;
    #2;
    chk("wdt_rst", wdt_err, 0);
    #3 rst_n = 1'b1;
`else
    nextCycle(); driveHash();
    for (int k = 1; k <= 12; k++) begin
      nextCycle(); id_valid = 1'b0; hfu_done = (k == 12);
      @(negedge clk);
      chk($sformatf("long%0d_state", k), dbgState, BUSY);
      chk($sformatf("long%0d_abort", k), hfu_abort, 0);
      chk($sformatf("long%0d_err", k), wdt_err, 0);
    end
    nextCycle(); hfu_done = 1'b0;
    @(negedge clk);
    chk("long_done", dbgState, DONE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
